// File: rtl/spi_slave_port_pkg.sv
// spi_slave_port_pkg
//   Shared constants for the SPI responder port.
//   - W_CPU / SPI_W_DATA_DEFAULT : default word length (CPU word width).
//   - spi_state_e                : FSM encoding (SPI_S_WAIT_IDLE, SPI_S_IDLE, SPI_S_SHIFT).
//   - SPI_MODE                   : {CPOL, CPHA}; this port implements mode 0.
package spi_slave_port_pkg;

  localparam int W_CPU              = 32;
  localparam int SPI_W_DATA_DEFAULT = W_CPU;

  typedef enum logic [1:0] {
    SPI_S_WAIT_IDLE = 2'd0,
    SPI_S_IDLE      = 2'd1,
    SPI_S_SHIFT     = 2'd2
  } spi_state_e;

  // {CPOL, CPHA}. CPOL also gives the idle level of spi_clk.
  localparam logic [1:0] SPI_MODE = 2'b00;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
//   Synchronizes one asynchronous pin into the clk domain and detects edges
//   from the last two synchronized samples.
//   Parameters: SYNC_STAGES (2..3), RESET_VAL (idle level of the pin).
//   Ports:
//     clk, rst  - local clock, async active-high reset
//     pin_i     - raw asynchronous pin
//     level_o   - synchronized level
//     rise_o    - one-cycle pulse on a synchronized 0->1 change
//     fall_o    - one-cycle pulse on a synchronized 1->0 change
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Resetting to the idle level (previous sample included) keeps reset
  // release from fabricating an edge on an idle pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_slave_port.sv
// spi_slave_port
//   SPI mode-0 responder. Oversamples spi_clk/spi_cs_n/spi_mosi in the clk
//   domain (clk >= 8x spi_clk), shifts MSB-first words in both directions and
//   supports back-to-back words while chip select stays low.
//   Optional feature macro: SPI_SLAVE_UNDERRUN_EN (adds tx_underrun, underrun_clr).
//   Ports:
//     clk, rst              - local clock, async active-high reset
//     spi_clk/cs_n/mosi     - master-driven serial pins
//     spi_miso, spi_miso_oe - serial data back to master and its enable
//     tx_data/valid/ready   - transmit word handshake into the holding register.
//                             A word moves when tx_valid && tx_ready on a clk
//                             edge; tx_ready is high exactly while the holding
//                             register is empty, and tx_data must be stable
//                             while tx_valid is high.
//     rx_data, rx_valid     - last complete received word, one-cycle pulse on update
//     busy                  - high in the SHIFT state
//     tx_underrun           - (optional) sticky: a load found no transmit word
//     underrun_clr          - (optional) clears tx_underrun
module spi_slave_port
  import spi_slave_port_pkg::*;
#(
  parameter int W_DATA      = SPI_W_DATA_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [W_DATA-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [W_DATA-1:0] rx_data,
  output logic              rx_valid,
`ifdef SPI_SLAVE_UNDERRUN_EN
  output logic              tx_underrun,
  input  logic              underrun_clr,
`endif
  output logic              busy
);

  localparam int CNT_W = $clog2(W_DATA) + 1;

  logic clk_lvl, clk_rise, clk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SPI_MODE[1])) u_sync_clk (
    .clk(clk), .rst(rst), .pin_i(spi_clk),
    .level_o(clk_lvl), .rise_o(clk_rise), .fall_o(clk_fall));

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .pin_i(spi_cs_n),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .pin_i(spi_mosi),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));

  spi_state_e        state_q, state_d;
  logic [1:0]        flush_q, flush_d;
  logic [W_DATA-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [W_DATA-1:0] tx_sh_q, tx_sh_d;
  logic [W_DATA-1:0] rx_sh_q, rx_sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              oe_q, oe_d;
  logic [W_DATA-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              load;
  logic [W_DATA-1:0] load_word;
  logic              tx_fire;

  assign tx_fire = tx_valid & ~hold_full_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SPI_S_WAIT_IDLE;
      flush_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      cnt_q       <= '0;
      oe_q        <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      cnt_q       <= cnt_d;
      oe_q        <= oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_d     = flush_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    cnt_d       = cnt_q;
    oe_d        = oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    load        = 1'b0;
    // A handshake coinciding with a load bypasses the holding register.
    load_word   = hold_full_q ? hold_q : (tx_fire ? tx_data : '0);

    case (state_q)
      SPI_S_WAIT_IDLE: begin
        // The synchronizer starts filled with the idle level, so cs_n must
        // read high for SYNC_STAGES+1 consecutive cycles before that level
        // is known to come from the pin rather than from reset.
        if (cs_lvl) begin
          if (flush_q == 2'(SYNC_STAGES)) state_d = SPI_S_IDLE;
          else                            flush_d = flush_q + 2'd1;
        end else begin
          flush_d = '0;
        end
      end
      SPI_S_IDLE: begin
        if (cs_fall) begin
          load    = 1'b1;
          oe_d    = 1'b1;
          cnt_d   = '0;
          state_d = SPI_S_SHIFT;
        end
      end
      SPI_S_SHIFT: begin
        if (clk_rise) begin
          rx_sh_d = {rx_sh_q[W_DATA-2:0], mosi_lvl};
          if (cnt_q == CNT_W'(W_DATA - 1)) begin
            rx_data_d  = rx_sh_d;
            rx_valid_d = 1'b1;
            cnt_d      = '0;
            // No reload when the frame is ending: the held word stays for
            // the next frame.
            load       = ~cs_rise;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (clk_fall && cnt_q != '0) begin
          // cnt_q == 0 here means the word was just reloaded and its MSB is
          // already on the pin; shifting now would skip it.
          tx_sh_d = {tx_sh_q[W_DATA-2:0], 1'b0};
        end
        if (cs_rise) begin
          state_d = SPI_S_IDLE;
          oe_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = SPI_S_WAIT_IDLE;
    endcase

    if (load) begin
      tx_sh_d     = load_word;
      hold_full_d = 1'b0;
    end else if (tx_fire) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic underrun_q;

  // A bypassed handshake counts as data present, not as an underrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      underrun_q <= 1'b0;
    else if (load && !hold_full_q && !tx_fire)    underrun_q <= 1'b1;
    else if (underrun_clr)                        underrun_q <= 1'b0;
  end

  assign tx_underrun = underrun_q;
`endif

  // MISO is the shift-register MSB while selected, so a load shows its MSB
  // immediately and deselect forces the pin low.
  assign spi_miso    = oe_q & tx_sh_q[W_DATA-1];
  assign spi_miso_oe = oe_q;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = (state_q == SPI_S_SHIFT);

  logic unused_sync;
  assign unused_sync = ^{clk_lvl, mosi_rise, mosi_fall, rx_sh_q[W_DATA-1]};

endmodule

// File: tb/tb_spi_slave_port.sv
module tb_spi_slave_port;

  localparam int W    = 32;
  localparam int HALF = 4;   // clk cycles per spi_clk half period (8x ratio)

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         spi_clk = 1'b0;
  logic         spi_cs_n = 1'b1;
  logic         spi_mosi = 1'b0;
  logic         spi_miso;
  logic         spi_miso_oe;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         busy;
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic         tx_underrun;
  logic         underrun_clr = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Received-word log, filled away from the active edge.
  int           rx_cnt = 0;
  logic [W-1:0] rx_log[$];

  always #5 clk = ~clk;

  spi_slave_port dut (
    .clk(clk), .rst(rst),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
`ifdef SPI_SLAVE_UNDERRUN_EN
    .tx_underrun(tx_underrun), .underrun_clr(underrun_clr),
`endif
    .busy(busy)
  );

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_cnt++;
      rx_log.push_back(rx_data);
    end
  end

  // Driver tasks: all start and end on a negedge of clk.
  task automatic tx_push(input logic [W-1:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Mode-0 master: data set on the falling edge, MISO sampled at the rise.
  task automatic master_bits(input logic [W-1:0] w, input int nbits, output logic [W-1:0] rd);
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = w[W-1-i];
      repeat (HALF) @(negedge clk);
      rd = {rd[W-2:0], spi_miso};
      spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++; if (spi_miso !== 1'b0)    begin n_err++; $display("FAIL reset_miso: got %b want 0", spi_miso); end
    n_vec++; if (spi_miso_oe !== 1'b0) begin n_err++; $display("FAIL reset_oe: got %b want 0", spi_miso_oe); end
    n_vec++; if (tx_ready !== 1'b1)    begin n_err++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    n_vec++; if (rx_data !== '0)       begin n_err++; $display("FAIL reset_rx_data: got %h want 0", rx_data); end
    n_vec++; if (rx_valid !== 1'b0)    begin n_err++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    n_vec++; if (busy !== 1'b0)        begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    n_vec++; if (busy !== 1'b0)        begin n_err++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_word();
    logic [W-1:0] rd;
    int n0;
    n0 = rx_cnt;
    tx_push(32'hA5A5_0F0F);
    n_vec++; if (tx_ready !== 1'b0)    begin n_err++; $display("FAIL t1_ready_full: got %b want 0", tx_ready); end
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    n_vec++; if (busy !== 1'b1)        begin n_err++; $display("FAIL t1_busy: got %b want 1", busy); end
    n_vec++; if (spi_miso_oe !== 1'b1) begin n_err++; $display("FAIL t1_oe: got %b want 1", spi_miso_oe); end
    n_vec++; if (tx_ready !== 1'b1)    begin n_err++; $display("FAIL t1_ready_back: got %b want 1", tx_ready); end
    master_bits(32'h1234_5678, 32, rd);
    cs_high();
    n_vec++; if (rd !== 32'hA5A5_0F0F) begin n_err++; $display("FAIL t1_miso_word: got %h want a5a50f0f", rd); end
    n_vec++; if (rx_cnt - n0 !== 1)    begin n_err++; $display("FAIL t1_rx_count: got %0d want 1", rx_cnt - n0); end
    n_vec++; if (rx_log[n0] !== 32'h1234_5678) begin n_err++; $display("FAIL t1_rx_word: got %h want 12345678", rx_log[n0]); end
    n_vec++; if (spi_miso_oe !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL t1_deselect: got oe=%b busy=%b want 0/0", spi_miso_oe, busy); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] rd0, rd1;
    int n0;
    n0 = rx_cnt;
    tx_push(32'h0000_0001);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    tx_push(32'h8000_0000);
    master_bits(32'hCAFE_F00D, 32, rd0);
    master_bits(32'h0123_4567, 32, rd1);
    cs_high();
    n_vec++; if (rd0 !== 32'h0000_0001) begin n_err++; $display("FAIL t2_miso_word0: got %h want 00000001", rd0); end
    n_vec++; if (rd1 !== 32'h8000_0000) begin n_err++; $display("FAIL t2_miso_word1: got %h want 80000000", rd1); end
    n_vec++; if (rx_cnt - n0 !== 2)     begin n_err++; $display("FAIL t2_rx_count: got %0d want 2", rx_cnt - n0); end
    n_vec++; if (rx_log[n0] !== 32'hCAFE_F00D)   begin n_err++; $display("FAIL t2_rx_word0: got %h want cafef00d", rx_log[n0]); end
    n_vec++; if (rx_log[n0+1] !== 32'h0123_4567) begin n_err++; $display("FAIL t2_rx_word1: got %h want 01234567", rx_log[n0+1]); end
  endtask

  task automatic test_partial_abort();
    logic [W-1:0] rd;
    int n0;
    n0 = rx_cnt;
    spi_cs_n = 1'b0;
    master_bits(32'hFFFF_FFFF, 13, rd);
    cs_high();
    n_vec++; if (rx_cnt !== n0)          begin n_err++; $display("FAIL t3_no_rx_valid: got %0d want %0d", rx_cnt, n0); end
    n_vec++; if (rx_data !== 32'h0123_4567) begin n_err++; $display("FAIL t3_rx_hold: got %h want 01234567", rx_data); end
    spi_cs_n = 1'b0;
    master_bits(32'h3C3C_5A5A, 32, rd);
    cs_high();
    n_vec++; if (rx_cnt - n0 !== 1)      begin n_err++; $display("FAIL t3_rx_count: got %0d want 1", rx_cnt - n0); end
    n_vec++; if (rx_data !== 32'h3C3C_5A5A) begin n_err++; $display("FAIL t3_rx_word: got %h want 3c3c5a5a", rx_data); end
  endtask

  task automatic test_underrun();
    logic [W-1:0] rd;
`ifdef SPI_SLAVE_UNDERRUN_EN
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    n_vec++; if (tx_underrun !== 1'b0) begin n_err++; $display("FAIL t5_underrun_pre: got %b want 0", tx_underrun); end
`endif
    n_vec++; if (tx_ready !== 1'b1)    begin n_err++; $display("FAIL t5_hold_empty: got %b want 1", tx_ready); end
    spi_cs_n = 1'b0;
    master_bits(32'h9696_6969, 32, rd);
    cs_high();
    n_vec++; if (rd !== 32'h0)         begin n_err++; $display("FAIL t5_miso_zero: got %h want 00000000", rd); end
    n_vec++; if (rx_data !== 32'h9696_6969) begin n_err++; $display("FAIL t5_rx_word: got %h want 96966969", rx_data); end
`ifdef SPI_SLAVE_UNDERRUN_EN
    n_vec++; if (tx_underrun !== 1'b1) begin n_err++; $display("FAIL t5_underrun_set: got %b want 1", tx_underrun); end
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    @(negedge clk);
    n_vec++; if (tx_underrun !== 1'b0) begin n_err++; $display("FAIL t5_underrun_clr: got %b want 0", tx_underrun); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] rd;
    int n0;
    n0 = rx_cnt;
    spi_cs_n = 1'b0;
    master_bits(32'hAAAA_AAAA, 10, rd);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    master_bits(32'h5555_5555, 22, rd);
    n_vec++; if (busy !== 1'b0)        begin n_err++; $display("FAIL t4_ignored_busy: got %b want 0", busy); end
    n_vec++; if (spi_miso_oe !== 1'b0) begin n_err++; $display("FAIL t4_ignored_oe: got %b want 0", spi_miso_oe); end
    cs_high();
    n_vec++; if (rx_cnt !== n0)        begin n_err++; $display("FAIL t4_no_rx_valid: got %0d want %0d", rx_cnt, n0); end
    n_vec++; if (rx_data !== '0)       begin n_err++; $display("FAIL t4_rx_cleared: got %h want 0", rx_data); end
    spi_cs_n = 1'b0;
    master_bits(32'hDEAD_BEEF, 32, rd);
    cs_high();
    n_vec++; if (rx_cnt - n0 !== 1)    begin n_err++; $display("FAIL t4_rx_count: got %0d want 1", rx_cnt - n0); end
    n_vec++; if (rx_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL t4_rx_word: got %h want deadbeef", rx_data); end
  endtask

  task automatic test_bypass();
    logic [W-1:0] rd;
    n_vec++; if (tx_ready !== 1'b1)    begin n_err++; $display("FAIL t6_ready_pre: got %b want 1", tx_ready); end
    // cs_n low here -> sampled at P0, synchronized level at P1, and cs_fall
    // is seen at the P2 edge; tx_valid is held across P2 only.
    spi_cs_n = 1'b0;
    repeat (2) @(negedge clk);
    tx_data  = 32'h5555_AAAA;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n_vec++; if (tx_ready !== 1'b1)    begin n_err++; $display("FAIL t6_ready_bypass: got %b want 1", tx_ready); end
    n_vec++; if (busy !== 1'b1)        begin n_err++; $display("FAIL t6_busy: got %b want 1", busy); end
    master_bits(32'h0F1E_2D3C, 32, rd);
    n_vec++; if (tx_ready !== 1'b1)    begin n_err++; $display("FAIL t6_ready_post: got %b want 1", tx_ready); end
    cs_high();
    n_vec++; if (rd !== 32'h5555_AAAA) begin n_err++; $display("FAIL t6_miso_word: got %h want 5555aaaa", rd); end
    n_vec++; if (rx_data !== 32'h0F1E_2D3C) begin n_err++; $display("FAIL t6_rx_word: got %h want 0f1e2d3c", rx_data); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_partial_abort();
    test_underrun();
    test_reset_mid_frame();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
- SPI peripheral (responder) end of the link the CPU-side SPI register file drives as master.
- Samples spi_clk, spi_cs_n and spi_mosi in the local clk domain, shifts MSB-first words in and out in SPI mode 0 (CPOL=0, CPHA=0), and presents received words with a one-cycle valid pulse.
- Accepts transmit words through a valid/ready handshake.
- Used as the bench-side counterpart for the CPU SPI path and as a peripheral front end.

Parameters:
- W_DATA, 32 (`W_CPU): word length in bits per SPI transfer.
- SYNC_STAGES, 2: synchronizer flops on spi_clk, spi_cs_n and spi_mosi; legal range 2..3.

Ports:
- clk  input  1  local clock; must run at least 8x spi_clk.
- rst  input  1  reset, asynchronous, active-high.
- spi_clk  input  1  serial clock from the master; idles low.
- spi_cs_n  input  1  chip select from the master, active-low.
- spi_mosi  input  1  serial data from the master.
- spi_miso  output  1  serial data to the master.
- spi_miso_oe  output  1  output enable for spi_miso; high while the frame is selected.
- tx_data  input  W_DATA  next word to send.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  holding register is empty.
- rx_data  output  W_DATA  last complete received word.
- rx_valid  output  1  one-cycle pulse when rx_data is updated.
- busy  output  1  high in the SHIFT state.

Behaviour:
- Reset values (async on rst):
  - spi_miso=0, spi_miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0.
  - Holding register empty, bit counter 0, state WAIT_IDLE.
  - Synchronizer flops reset to idle levels: spi_cs_n=1, spi_clk=0.
- Edge detection: rise, fall, cs_fall and cs_rise are computed from the last two synchronized samples. A pin change becomes visible SYNC_STAGES+1 clk cycles later.
- States:
  - WAIT_IDLE: entered after reset. Moves to IDLE once synchronized cs_n=1. A frame already in progress at reset release is therefore ignored.
  - IDLE: on cs_fall, load the shift register from the holding register, or from all-zeros if the holding register is empty. Drive spi_miso = shift MSB, set spi_miso_oe=1, set the bit counter to 0, go to SHIFT.
  - SHIFT, on rise: shift the synchronized mosi into the rx shift register LSB and increment the bit counter.
  - SHIFT, on fall: shift the tx register left by one and drive the new MSB onto spi_miso.
  - SHIFT, word complete (counter reaches W_DATA on a rise):
    - Copy the rx shift register to rx_data in the following cycle and pulse rx_valid for one cycle.
    - Reset the counter to 0.
    - Reload the tx shift register from the holding register (or zeros) and present the new MSB on spi_miso immediately. This supports back-to-back words while cs stays low.
  - SHIFT, on cs_rise: go to IDLE and set spi_miso_oe=0, spi_miso=0. A partial word (counter not 0) is discarded, with no rx_valid and rx_data unchanged.
- TX handshake:
  - A transfer occurs when tx_valid & tx_ready. It fills the holding register, and tx_ready drops the next cycle.
  - tx_ready rises the cycle after the holding register is consumed by a frame start or word reload.
  - If a handshake coincides with a load event, the incoming tx_data bypasses straight into the shift register and the holding register stays empty.
- Simultaneous events:
  - cs_rise in the same cycle as a completing rise: the word completes (rx_valid pulses) and the block then goes to IDLE.
  - rise and fall in the same cycle are impossible at the 8x clock ratio and need not be handled.
- Counter width is clog2(W_DATA)+1. The counter never wraps past W_DATA.

Optional Feature:
- Macro: SPI_SLAVE_UNDERRUN_EN.
- Defined:
  - Adds output tx_underrun (1 bit) and input underrun_clr (1 bit).
  - tx_underrun is sticky: set when a frame-start or word-reload load event finds the holding register empty.
  - Cleared by underrun_clr; set has priority when both occur in the same cycle. Reset value 0.
- Undefined: both ports are absent, and zeros are shifted silently on underrun.

Decomposition:
- Shared include, next to lib/opcodes.v:
  - W_CPU-derived W_DATA default.
  - State encoding constants SPI_S_WAIT_IDLE, SPI_S_IDLE, SPI_S_SHIFT.
  - SPI mode constant.
- Sub-module spi_sync_edge: one per input pin. Contains the SYNC_STAGES synchronizer plus the previous-sample flop, and outputs level, rise and fall.
- Everything else stays in spi_slave_port.

Test Plan:
1. Reset, then load tx 0xA5A5_0F0F; master sends 0x1234_5678 with cs low for 32 clocks -> master reads 0xA5A5_0F0F on MISO; exactly one rx_valid pulse with rx_data=0x1234_5678; tx_ready back to 1 after frame start.
2. Load 0x0000_0001, then 0x8000_0000 while the first word is shifting; master sends two words with cs held low -> MISO carries both words in order; two rx_valid pulses with the matching master words; no gap bit.
3. Raise cs after 13 bits of 0xFFFF_FFFF -> no rx_valid; rx_data holds its previous value; the next full frame is received correctly.
4. Assert rst mid-frame with cs still low, release it, finish the frame, then run a clean frame of 0xDEAD_BEEF -> no rx_valid until cs goes high; the clean frame gives rx_data=0xDEAD_BEEF.
5. Start a frame with no tx loaded -> MISO is all zeros; with SPI_SLAVE_UNDERRUN_EN, tx_underrun=1 until an underrun_clr pulse, then 0.
6. Assert tx_valid in the exact cycle cs_fall is detected with tx_data 0x5555_AAAA -> the word is sent in the current frame and tx_ready stays 1.
